// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Command handshake between a host controller and the PS/2 host transmitter.
//   tx_data   [7:0]  byte to send (master -> slave)
//   tx_valid         send request, taken when tx_valid & tx_ready
//   tx_ready         transmitter idle and able to take a byte
//   busy             transmitter owns the PS/2 bus; receivers must ignore it
//   done             one-cycle pulse: byte sent and acknowledged by the device
//   err              one-cycle pulse: transfer aborted (timeout or no ACK)
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
// clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop,
// then checks the device ACK and waits for the bus to return idle.
// Pins are driven open-drain: *_oe_o = 1 pulls the line low, the pad is
// expected to be  pin = oe ? 1'b0 : 1'bz.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   tx_if          command handshake (slave side), see ps2_host_tx_if
//   ps2_clk_i      PS/2 clock pin level (asynchronous)
//   ps2_data_i     PS/2 data pin level (asynchronous)
//   ps2_clk_oe_o   1 = pull PS/2 clock low
//   ps2_data_oe_o  1 = pull PS/2 data low
//
// Parameters
//   INHIBIT_CYC    total cycles the clock line is held low by the host,
//                  including the final request-to-send cycle (must be >= 4)
//   TIMEOUT_CYC    max cycles between device clock falls before abort
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus released, tx_ready=1, waiting for tx_valid
// S_INHIBIT  | host pulls clock low to stop any device transmission
// S_RTS      | start bit (data low) driven, clock still held, one cycle
// S_SHIFT    | clock released; each device fall puts data/parity bit out
// S_STOP     | next fall releases data (stop bit = 1)
// S_ACK      | next fall samples device ACK (data must be low)
// S_WAIT_IDLE| wait for clock and data both high two cycles in a row
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 3000,
  parameter int unsigned TIMEOUT_CYC = 405000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ps2_host_tx_if.slave  tx_if,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe_o,
  output logic          ps2_data_oe_o
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);

  // INHIBIT lasts INHIBIT_CYC-1 cycles; the RTS cycle keeps the clock held
  // too, so the clock line is low for exactly INHIBIT_CYC cycles overall.
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  // -------------------------------------------------------------------------
  // Pin synchronizers and falling-edge detect on the clock line.
  // Reset to 1 (idle bus level) so leaving reset never looks like a fall.
  // -------------------------------------------------------------------------
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic clk_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_sync_q;

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  state_e            state_q;
  logic [8:0]        shift_q;      // {parity, data}; bit 0 is next to go out
  logic [3:0]        bitcnt_q;
  logic [INH_W-1:0]  inh_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              idle_seen_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              clk_oe_q;
  logic              data_oe_q;
  logic              tx_parity_d;
  logic              in_watch;

  assign tx_parity_d = ~^tx_if.tx_data;

  // Device-clocked phase, where a stalled device must be caught.
  assign in_watch = (state_q == S_RTS)   || (state_q == S_SHIFT) ||
                    (state_q == S_STOP)  || (state_q == S_ACK)   ||
                    (state_q == S_WAIT_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      idle_seen_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (tx_if.tx_valid) begin
            shift_q     <= {tx_parity_d, tx_if.tx_data};
            inh_cnt_q   <= INH_LOAD;
            to_cnt_q    <= '0;
            bitcnt_q    <= '0;
            idle_seen_q <= 1'b0;
            clk_oe_q    <= 1'b1;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt_q == '0) begin
            data_oe_q <= 1'b1;
            state_q   <= S_RTS;
          end else begin
            inh_cnt_q <= inh_cnt_q - INH_W'(1);
          end
        end

        S_RTS: begin
          clk_oe_q <= 1'b0;
          bitcnt_q <= '0;
          state_q  <= S_SHIFT;
        end

        S_SHIFT: begin
          if (clk_fall) begin
            data_oe_q <= ~shift_q[0];
            shift_q   <= {1'b0, shift_q[8:1]};
            bitcnt_q  <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd8) begin
              state_q <= S_STOP;
            end
          end
        end

        S_STOP: begin
          if (clk_fall && (bitcnt_q == 4'd9)) begin
            data_oe_q <= 1'b0;
            bitcnt_q  <= bitcnt_q + 4'd1;
            state_q   <= S_ACK;
          end
        end

        S_ACK: begin
          if (clk_fall) begin
            if (!data_sync_q) begin
              idle_seen_q <= 1'b0;
              state_q     <= S_WAIT_IDLE;
            end else begin
              err_q   <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        S_WAIT_IDLE: begin
          if (clk_sync_q && data_sync_q) begin
            if (idle_seen_q) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idle_seen_q <= 1'b1;
            end
          end else begin
            idle_seen_q <= 1'b0;
          end
        end

        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase

      // Timeout has the last word: it overrides any done from the same
      // cycle, so done and err can never pulse together.
      if (in_watch) begin
        if (clk_fall) begin
          to_cnt_q <= '0;
        end else if (to_cnt_q == TO_LAST) begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b1;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_if.busy     = busy_q;
  assign tx_if.done     = done_q;
  assign tx_if.err      = err_q;
  assign ps2_clk_oe_o   = clk_oe_q;
  assign ps2_data_oe_o  = data_oe_q;

endmodule
